instr_encoder: RTL and testbench

- Inverse of the decode-stage immediate extraction: packs an operation class, register fields and a 64-bit signed immediate into a 32-bit LEGv8 instruction word.
- Range-checks and truncates the immediate to its field width. Sits in the program loader path and feeds instruction memory with sequential word addresses.
- Two-stage valid/ready pipeline, throughput one instruction per cycle.

---
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: packs class/registers/immediate into a 32-bit word, range-checks the immediate,
// and emits it with a sequential word address through a 2-stage valid/ready pipeline. Optional macro: ENCODER_SAT_EN.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_class,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rn,
  input  logic [`WORD-1:0]      in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`INSTR_LEN-1:0] out_instr,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_err,
  output logic [7:0]            err_count
);

  logic                  s1_valid;
  logic [`INSTR_LEN-1:0] s1_instr;
  logic                  s1_err;
  logic                  s1_advance;

  logic                  fit9, fit26, fit19;
  logic [8:0]            sat9;
  logic [25:0]           sat26;
  logic [18:0]           sat19;
  logic [8:0]            f9;
  logic [25:0]           f26;
  logic [18:0]           f19;
  logic [`INSTR_LEN-1:0] pack;
  logic                  pack_err;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  // An immediate fits an N-bit field when every bit from 63 down to N-1 is a copy of the sign.
  assign fit9  = (&in_imm[63:8])  | ~(|in_imm[63:8]);
  assign fit26 = (&in_imm[63:25]) | ~(|in_imm[63:25]);
  assign fit19 = (&in_imm[63:18]) | ~(|in_imm[63:18]);

`ifdef ENCODER_SAT_EN
  assign sat9  = in_imm[63] ? 9'h100     : 9'h0FF;
  assign sat26 = in_imm[63] ? 26'h2000000 : 26'h1FFFFFF;
  assign sat19 = in_imm[63] ? 19'h40000  : 19'h3FFFF;
`else
  assign sat9  = '0;
  assign sat26 = '0;
  assign sat19 = '0;
`endif

  assign f9  = fit9  ? in_imm[8:0]  : sat9;
  assign f26 = fit26 ? in_imm[25:0] : sat26;
  assign f19 = fit19 ? in_imm[18:0] : sat19;

  always_comb begin
    pack     = '0;
    pack_err = 1'b0;
    case (in_class)
      2'd0: begin
        pack     = {11'b11111000010, f9, 2'b00, in_rn, in_rt};
        pack_err = !fit9;
      end
      2'd1: begin
        pack     = {11'b11111000000, f9, 2'b00, in_rn, in_rt};
        pack_err = !fit9;
      end
      2'd2: begin
        pack     = {6'b000101, f26};
        pack_err = !fit26;
      end
      default: begin
        pack     = {8'b10110100, f19, in_rt};
        pack_err = !fit19;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_instr  <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= '0;
      err_count <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_instr <= pack;
        s1_err   <= pack_err;
      end
      // Output register only loads when the consumer has drained it, keeping out_* stable under stall.
      if (s1_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= s1_instr;
          out_err   <= s1_err;
        end
      end
      if (out_valid && out_ready) begin
        out_addr <= out_addr + ADDR_W'(1);
        if (out_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table plus hand sequences, scoreboard-checked outputs.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_class = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rn = '0;
  logic [63:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [1:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  instr_encoder #(.ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rt(in_rt), .in_rn(in_rn), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

`ifdef ENCODER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [1:0]  cls;
    logic [4:0]  rt;
    logic [4:0]  rn;
    logic [63:0] imm;
    logic [31:0] exp_zero;
    logic [31:0] exp_sat;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  int checks = 0;
  int failures = 0;

  logic [32:0] sbq[$];
  logic [31:0] cur_instr;
  logic        cur_err;
  logic [1:0]  exp_addr = '0;
  logic [7:0]  exp_errcnt = '0;
  bit          mon_en = 1'b0;
  bit          held_v = 1'b0;
  logic [31:0] held_instr;
  logic [1:0]  held_addr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word got=%h exp=none", out_instr);
        end else begin
          logic [32:0] e;
          e = sbq.pop_front();
          chk("out_instr", {32'd0, out_instr}, {32'd0, e[31:0]});
          chk("out_err", {63'd0, out_err}, {63'd0, e[32]});
          chk("out_addr", {62'd0, out_addr}, {62'd0, exp_addr});
          chk("err_count", {56'd0, err_count}, {56'd0, exp_errcnt});
          exp_addr = exp_addr + 2'd1;
          if (e[32] && exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
        end
      end
      if (out_valid && !out_ready) begin
        if (held_v) begin
          chk("stall_instr", {32'd0, out_instr}, {32'd0, held_instr});
          chk("stall_addr", {62'd0, out_addr}, {62'd0, held_addr});
        end
        held_v     = 1'b1;
        held_instr = out_instr;
        held_addr  = out_addr;
      end else begin
        held_v = 1'b0;
      end
      if (in_valid && in_ready) sbq.push_back({cur_err, cur_instr});
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send(input logic [1:0] cls, input logic [4:0] rt, input logic [4:0] rn,
                      input logic [63:0] imm, input logic [31:0] ei, input logic ee);
    bit done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_class  = cls;
    in_rt     = rt;
    in_rn     = rn;
    in_imm    = imm;
    cur_instr = ei;
    cur_err   = ee;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=none exp=accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int i);
    send(vecs[i].cls, vecs[i].rt, vecs[i].rn, vecs[i].imm,
         SAT ? vecs[i].exp_sat : vecs[i].exp_zero, vecs[i].err);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk);
      if (sbq.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", sbq.size());
    end
    #1;
  endtask

  initial begin
    //          cls   rt     rn     imm                      zero-mode     sat-mode      err
    vecs[0]  = '{2'd0, 5'd1,  5'd2,  64'd8,                   32'hF8408041, 32'hF8408041, 1'b0};
    vecs[1]  = '{2'd1, 5'd4,  5'd3,  -64'sd8,                 32'hF81F8064, 32'hF81F8064, 1'b0};
    vecs[2]  = '{2'd2, 5'd0,  5'd0,  -64'sd1,                 32'h17FFFFFF, 32'h17FFFFFF, 1'b0};
    vecs[3]  = '{2'd3, 5'd5,  5'd0,  64'd4,                   32'hB4000085, 32'hB4000085, 1'b0};
    vecs[4]  = '{2'd0, 5'd1,  5'd2,  64'd256,                 32'hF8400041, 32'hF84FF041, 1'b1};
    vecs[5]  = '{2'd0, 5'd1,  5'd2,  -64'sd256,               32'hF8500041, 32'hF8500041, 1'b0};
    vecs[6]  = '{2'd2, 5'd0,  5'd0,  64'h0000000002000000,    32'h14000000, 32'h15FFFFFF, 1'b1};
    vecs[7]  = '{2'd3, 5'd7,  5'd0,  -64'sd262144,            32'hB4800007, 32'hB4800007, 1'b0};
    vecs[8]  = '{2'd3, 5'd7,  5'd0,  -64'sd262145,            32'hB4000007, 32'hB4800007, 1'b1};
    vecs[9]  = '{2'd1, 5'd31, 5'd31, 64'd255,                 32'hF80FF3FF, 32'hF80FF3FF, 1'b0};
    vecs[10] = '{2'd2, 5'd0,  5'd0,  64'h8000000000000000,    32'h14000000, 32'h16000000, 1'b1};
    vecs[11] = '{2'd2, 5'd5,  5'd6,  64'd3,                   32'h14000003, 32'h14000003, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_addr", {62'd0, out_addr}, 64'd0);
    chk("rst_err_count", {56'd0, err_count}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    mon_en    = 1'b1;
    out_ready = 1'b1;

    // Two-cycle latency from accept to out_valid
    send_vec(0);
    @(negedge clk);
    chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    drain();

    // Table, back to back, covering address wrap
    for (int i = 0; i < 12; i++) send_vec(i);
    drain();

    // Backpressure: two words buffered, third held off for 3 cycles
    out_ready = 1'b0;
    send_vec(1);
    send_vec(2);
    fork
      send_vec(3);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send_vec(9);
    drain();

    // Saturating error counter
    for (int i = 0; i < 260; i++) send_vec(4);
    drain();
    chk("err_count_sat", {56'd0, err_count}, 64'd255);

    // Reset with both stages full
    out_ready = 1'b0;
    send_vec(5);
    send_vec(6);
    @(negedge clk);
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_addr", {62'd0, out_addr}, 64'd0);
    chk("midrst_err_count", {56'd0, err_count}, 64'd0);
    sbq.delete();
    exp_addr   = '0;
    exp_errcnt = '0;
    @(posedge clk);
    #3;
    reset     = 1'b0;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    @(posedge clk);
    #1;
    send_vec(3);
    send_vec(8);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
